// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sync polarity helper and scan FSM state type
// for the vga_scan_ctrl block.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  // Both syncs are active-low on the connector.
  localparam logic SYNC_POL = 1'b0;

  localparam int CNT_W = 10;

  typedef enum logic {PRIME, RUN} scan_state_e;

  function automatic logic sync_level(input logic pulse);
    return pulse ? SYNC_POL : ~SYNC_POL;
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Pixel-FIFO read side and VGA pin bundle of vga_scan_ctrl.
// VGA_TEST_PATTERN_EN adds the pattern_sel input.
interface vga_scan_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] pixel_r;
  logic [DATA_W-1:0] pixel_g;
  logic [DATA_W-1:0] pixel_b;
  logic              rd_fifo;
  logic [DATA_W-1:0] vga_r;
  logic [DATA_W-1:0] vga_g;
  logic [DATA_W-1:0] vga_b;
  logic              hsync;
  logic              vsync;
  logic              blank;
  logic              frame_start;
  logic              underflow;
`ifdef VGA_TEST_PATTERN_EN
  logic              pattern_sel;

  modport master (
    output fifo_empty, pixel_r, pixel_g, pixel_b, pattern_sel,
    input  rd_fifo, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start, underflow
  );
  modport slave (
    input  fifo_empty, pixel_r, pixel_g, pixel_b, pattern_sel,
    output rd_fifo, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start, underflow
  );
`else
  modport master (
    output fifo_empty, pixel_r, pixel_g, pixel_b,
    input  rd_fifo, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start, underflow
  );
  modport slave (
    input  fifo_empty, pixel_r, pixel_g, pixel_b,
    output rd_fifo, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start, underflow
  );
`endif
endinterface

// File: rtl/vga_hv_counter.sv
// Horizontal/vertical scan position counters; advance only while enabled,
// wrapping at the end of each line and frame.
module vga_hv_counter
  import vga_timing_pkg::*;
#(
  parameter int H_COUNT = H_TOTAL,
  parameter int V_COUNT = V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             origin
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_COUNT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_COUNT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign origin = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: primes on the pixel FIFO, then generates timing, reads
// the FIFO one cycle ahead and drives 2-cycle-aligned RGB/sync/blank pins.
// Optional colour-bar generator behind VGA_TEST_PATTERN_EN.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic            clk_25mhz,
  input  logic            rst,
  vga_scan_ctrl_if.slave  vga
);

  localparam int H_LINE  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_FRAME = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  scan_state_e      state;
  logic             run_p0;
  logic [CNT_W-1:0] h_p0;
  logic [CNT_W-1:0] v_p0;
  logic             origin_p0;
  logic             active_p0;
  logic             hs_p0;
  logic             vs_p0;
  logic             fs_p0;
  logic             rd_p0;
  logic             uf_p0;

  logic             vld_p1;
  logic             act_p1;
  logic             hs_p1;
  logic             vs_p1;
  logic             fs_p1;
  logic             uf_p1;

  logic [3*DATA_W-1:0] rgb_p2;
  logic                hsync_p2;
  logic                vsync_p2;
  logic                blank_p2;
  logic                fs_p2;
  logic                underflow_p2;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      case (state)
        PRIME:   if (!vga.fifo_empty) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign run_p0 = (state == RUN);

  vga_hv_counter #(
    .H_COUNT (H_LINE),
    .V_COUNT (V_FRAME)
  ) u_hv_counter (
    .clk    (clk_25mhz),
    .rst    (rst),
    .en     (run_p0),
    .h      (h_p0),
    .v      (v_p0),
    .origin (origin_p0)
  );

  // Stage 0: decode the current scan position
  assign active_p0 = run_p0 && (h_p0 < H_ACT_C) && (v_p0 < V_ACT_C);
  assign hs_p0     = run_p0 && (h_p0 >= HS_FIRST) && (h_p0 <= HS_LAST);
  assign vs_p0     = run_p0 && (v_p0 >= VS_FIRST) && (v_p0 <= VS_LAST);
  assign fs_p0     = run_p0 && origin_p0;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic                pat_mode;
  logic                pat_p0;
  logic [CNT_W-1:0]    bar_p0;
  logic                pat_p1;
  logic [3*DATA_W-1:0] pat_rgb_p1;

  function automatic logic [3*DATA_W-1:0] bar_colour(input logic [2:0] idx);
    return {{DATA_W{idx[2]}}, {DATA_W{idx[1]}}, {DATA_W{idx[0]}}};
  endfunction

  // The origin pixel already uses the value being sampled for its frame.
  assign pat_p0 = origin_p0 ? vga.pattern_sel : pat_mode;
  assign bar_p0 = h_p0 / CNT_W'(BAR_W);
  assign rd_p0  = active_p0 && !vga.fifo_empty && !pat_p0;
  assign uf_p0  = active_p0 && vga.fifo_empty && !pat_p0;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      pat_mode   <= 1'b0;
      pat_p1     <= 1'b0;
      pat_rgb_p1 <= '0;
    end else begin
      if (fs_p0) pat_mode <= vga.pattern_sel;
      pat_p1     <= active_p0 && pat_p0;
      pat_rgb_p1 <= bar_colour(bar_p0[2:0]);
    end
  end
`else
  assign rd_p0 = active_p0 && !vga.fifo_empty;
  assign uf_p0 = active_p0 && vga.fifo_empty;
`endif

  // Stage 1: FIFO dout becomes valid for reads issued in stage 0
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      act_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
      uf_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
      act_p1 <= active_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0;
      uf_p1  <= uf_p0;
    end
  end

  // Stage 2: output pin registers
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      rgb_p2       <= '0;
      hsync_p2     <= ~SYNC_POL;
      vsync_p2     <= ~SYNC_POL;
      blank_p2     <= 1'b1;
      fs_p2        <= 1'b0;
      underflow_p2 <= 1'b0;
    end else begin
      if (vld_p1)
        rgb_p2 <= {vga.pixel_r, vga.pixel_g, vga.pixel_b};
`ifdef VGA_TEST_PATTERN_EN
      else if (pat_p1)
        rgb_p2 <= pat_rgb_p1;
`endif
      else
        rgb_p2 <= '0;
      hsync_p2     <= sync_level(hs_p1);
      vsync_p2     <= sync_level(vs_p1);
      blank_p2     <= ~act_p1;
      fs_p2        <= fs_p1;
      underflow_p2 <= underflow_p2 | uf_p1;
    end
  end

  assign vga.rd_fifo     = rd_p0;
  assign vga.vga_r       = rgb_p2[3*DATA_W-1:2*DATA_W];
  assign vga.vga_g       = rgb_p2[2*DATA_W-1:DATA_W];
  assign vga.vga_b       = rgb_p2[DATA_W-1:0];
  assign vga.hsync       = hsync_p2;
  assign vga.vsync       = vsync_p2;
  assign vga.blank       = blank_p2;
  assign vga.frame_start = fs_p2;
  assign vga.underflow   = underflow_p2;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomized bench for vga_scan_ctrl on a reduced raster, compared every
// cycle against a position-arithmetic reference model.
module tb_vga_scan_ctrl;

  localparam int HA = 40, HFP = 6, HS = 10, HBP = 8;
  localparam int VA = 12, VFP = 3, VS = 2, VBP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  typedef struct packed {
    logic        rd;
    logic        hs_n;
    logic        vs_n;
    logic        blank;
    logic        fs;
    logic        uf;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t IDLE = '{rd: 1'b0, hs_n: 1'b1, vs_n: 1'b1, blank: 1'b1,
                            fs: 1'b0, uf: 1'b0, rgb: 24'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_scan_ctrl_if #(.DATA_W(8)) vif ();

  vga_scan_ctrl #(
    .DATA_W   (8),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
  ) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .vga       (vif)
  );

  int checks = 0;
  int errors = 0;

  bit          run;
  int          r;
  exp_t        s0m, p1m, outm;
  bit          ufm;
  logic [23:0] cur_pix;
  bit          prev_empty;
  bit          rst_prev;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected stage-0 view of RUN cycle number rc (0 = first RUN cycle).
  function automatic exp_t stage0(input bit running, input int rc, input bit empty);
    exp_t e;
    int   h, v;
    bit   act;
    e = IDLE;
    h = rc % HT;
    v = (rc / HT) % VT;
    if (running) begin
      act     = (h < HA) && (v < VA);
      e.rd    = act && !empty;
      e.uf    = act && empty;
      e.blank = !act;
      e.hs_n  = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs_n  = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.fs    = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  // mode 0: FIFO empty, 1: never empty, 2: random empties plus a forced gap at line 5
  task automatic step(input int mode, input bit arm_rst, output bit fired);
    bit empty;
    int h, v;
    fired = 1'b0;
    @(posedge clk);
    #1;
    if (!rst_prev) begin
      outm     = p1m;
      outm.rgb = p1m.rd ? cur_pix : 24'd0;
      ufm      = ufm | p1m.uf;
      p1m      = s0m;
      if (run) r = (r + 1) % (HT * VT);
      else if (!prev_empty) begin
        run = 1'b1;
        r   = 0;
      end
    end
    rst      = 1'b0;
    rst_prev = 1'b0;
    h = r % HT;
    v = (r / HT) % VT;
    case (mode)
      0:       empty = 1'b1;
      1:       empty = 1'b0;
      default: empty = ($urandom_range(0, 15) == 0);
    endcase
    if (mode == 2 && run && v == 5) empty = (h >= 10 && h <= 13);
    cur_pix        = 24'($urandom);
    vif.fifo_empty = empty;
    vif.pixel_r    = cur_pix[23:16];
    vif.pixel_g    = cur_pix[15:8];
    vif.pixel_b    = cur_pix[7:0];
    s0m            = stage0(run, r, empty);
    prev_empty     = empty;
    if (arm_rst && run && h == 20 && v == 7) begin
      #2 rst = 1'b1;
      #1;
      chk_val("async_rst_rd_fifo", vif.rd_fifo, 0);
      chk_val("async_rst_hsync", vif.hsync, 1);
      chk_val("async_rst_vsync", vif.vsync, 1);
      chk_val("async_rst_blank", vif.blank, 1);
      chk_val("async_rst_vga_g", vif.vga_g, 0);
      chk_val("async_rst_underflow", vif.underflow, 0);
      run      = 1'b0;
      r        = 0;
      s0m      = IDLE;
      p1m      = IDLE;
      outm     = IDLE;
      ufm      = 1'b0;
      rst_prev = 1'b1;
      fired    = 1'b1;
    end
    @(negedge clk);
    chk_val("rd_fifo", vif.rd_fifo, s0m.rd);
    chk_val("hsync", vif.hsync, outm.hs_n);
    chk_val("vsync", vif.vsync, outm.vs_n);
    chk_val("blank", vif.blank, outm.blank);
    chk_val("frame_start", vif.frame_start, outm.fs);
    chk_val("vga_r", vif.vga_r, outm.rgb[23:16]);
    chk_val("vga_g", vif.vga_g, outm.rgb[15:8]);
    chk_val("vga_b", vif.vga_b, outm.rgb[7:0]);
    chk_val("underflow", vif.underflow, ufm);
  endtask

  initial begin
    bit f;
    int rd_cnt, hs_low, vs_low, fs_cnt, n;
`ifdef VGA_TEST_PATTERN_EN
    vif.pattern_sel = 1'b0;
`endif
    vif.fifo_empty = 1'b1;
    vif.pixel_r    = '0;
    vif.pixel_g    = '0;
    vif.pixel_b    = '0;
    run        = 1'b0;
    r          = 0;
    s0m        = IDLE;
    p1m        = IDLE;
    outm       = IDLE;
    ufm        = 1'b0;
    cur_pix    = '0;
    prev_empty = 1'b1;
    rst_prev   = 1'b1;

    repeat (100) step(0, 1'b0, f);

    rd_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
    repeat (HT * VT + 1) begin
      step(1, 1'b0, f);
      rd_cnt += int'(vif.rd_fifo);
      hs_low += int'(!vif.hsync);
      vs_low += int'(!vif.vsync);
      fs_cnt += int'(vif.frame_start);
    end
    chk_val("frame_rd_pulses", rd_cnt, HA * VA);
    chk_val("frame_hsync_low_cycles", hs_low, VT * HS);
    chk_val("frame_vsync_low_cycles", vs_low, VS * HT);
    chk_val("frame_start_pulses", fs_cnt, 1);

    n = 0;
    f = 1'b0;
    while (!f && n < 3 * HT * VT) begin
      step(2, n > HT * VT, f);
      n++;
    end

    repeat (60) step(0, 1'b0, f);
    repeat (HT * VT + 200) step(2, 1'b0, f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
